// File: rtl/seq_barrel_rotator_if.sv
// Operand/command/result bundle for seq_barrel_rotator.
// The master drives a request; the slave returns the working register and status.
interface seq_barrel_rotator_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             dir;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;

  modport master (
    output start, data_in, dir, mode, amount,
    input  data_out, busy, done
  );

  modport slave (
    input  start, data_in, dir, mode, amount,
    output data_out, busy, done
  );
endinterface

// File: rtl/seq_barrel_rotator.sv
// Multi-cycle rotate/shift engine: captures an operand, then applies one
// single-bit rotate/logical/arithmetic step per clock until the count expires.
module seq_barrel_rotator #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_barrel_rotator_if.slave  bus
);

  localparam logic [1:0] MODE_ROT = 2'b00;
  localparam logic [1:0] MODE_LSH = 2'b01;
  localparam logic [1:0] MODE_ASH = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic [AMT_W-1:0] r_cnt;
  logic [AMT_W-1:0] w_cnt_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_step;

  // Single-bit step of the working register; reserved mode falls back to rotate.
  always_comb begin
    w_step = r_data;
    if (r_dir) begin
      unique case (r_mode)
        MODE_LSH, MODE_ASH: w_step = {r_data[WIDTH-2:0], 1'b0};
        default:            w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
      endcase
    end else begin
      unique case (r_mode)
        MODE_LSH: w_step = {1'b0, r_data[WIDTH-1:1]};
        MODE_ASH: w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
        MODE_ROT: w_step = {r_data[0], r_data[WIDTH-1:1]};
        default:  w_step = {r_data[0], r_data[WIDTH-1:1]};
      endcase
    end
  end

  // Next-state and datapath-load logic.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_mode_nxt  = r_mode;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          w_data_nxt  = bus.data_in;
          w_cnt_nxt   = bus.amount;
          w_dir_nxt   = bus.dir;
          w_mode_nxt  = bus.mode;
          w_state_nxt = (bus.amount != '0) ? ST_SHIFT : ST_DONE;
        end else if (r_state == ST_DONE) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_data_nxt = w_step;
        w_cnt_nxt  = r_cnt - AMT_W'(1);
        // A count of 1 (or a defensive 0) means this is the final step.
        if (r_cnt <= AMT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_mode  <= MODE_ROT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_mode  <= w_mode_nxt;
      r_busy  <= (w_state_nxt == ST_SHIFT);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.data_out = r_data;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: doc/seq_barrel_rotator.md
# seq_barrel_rotator

Parametrised, multi-cycle rotate/shift engine: the sequential successor to the 4-bit single-step right rotator. It captures a WIDTH-bit operand, then rotates or shifts it left or right by a programmable amount, one bit position per clock. It reports progress with `busy` and a one-cycle `done` pulse. It sits in the datapath exercises as the shift unit feeding later ALU-style blocks.

## Interface
- `WIDTH`, default 4: operand width in bits, ≥ 2.
- `AMT_W`, default $clog2(WIDTH)+1: width of `amount`, so an amount of WIDTH itself is representable.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: request a new operation; sampled only in IDLE or DONE.
- `data_in`, input, WIDTH: operand, captured on an accepted `start`.
- `dir`, input, 1: 0 = right (toward bit 0), 1 = left (toward bit WIDTH-1); captured on `start`.
- `mode`, input, 2: 00 = rotate, 01 = logical shift, 10 = arithmetic shift, 11 = reserved (behaves as rotate); captured on `start`.
- `amount`, input, AMT_W: number of single-bit steps; captured on `start`.
- `data_out`, output, WIDTH: working register, always driven. Holds the result while in DONE/IDLE and intermediate values while busy.
- `busy`, output, 1: high while in SHIFT.
- `done`, output, 1: high for exactly one cycle, in DONE.

## Operation
- States:
  - IDLE: reset state; waiting for `start`.
  - SHIFT: one step per cycle.
  - DONE: result-valid pulse.
- Accept: `start`=1 in IDLE or DONE loads `data_out`←`data_in` and `cnt`←`amount`, and latches `dir`/`mode`. The next state is SHIFT if `amount`≠0, else DONE.
- Non-accept:
  - `start` in SHIFT is ignored; it is neither queued nor restarted.
  - DONE with no `start` returns to IDLE.
  - IDLE with no `start` holds.
- One step in SHIFT, applied to the register value r:
  - Rotate right: {r[0], r[WIDTH-1:1]}. Rotate left: {r[WIDTH-2:0], r[WIDTH-1]}.
  - Logical right: {1'b0, r[WIDTH-1:1]}. Logical left: {r[WIDTH-2:0], 1'b0}.
  - Arithmetic right: {r[WIDTH-1], r[WIDTH-1:1]}. Arithmetic left is identical to logical left.
- Counter:
  - Each SHIFT cycle applies one step and decrements `cnt`.
  - When `cnt`==1 at the edge, the last step is applied and the next state is DONE.
- Amount semantics, any value 0..2^AMT_W-1 (values above WIDTH are legal):
  - Rotate by WIDTH returns the operand unchanged.
  - Logical shift by ≥ WIDTH gives all zeros.
  - Arithmetic right by ≥ WIDTH-1 gives all copies of the sign bit.
- `data_out` holds its value in IDLE and DONE; it changes only on accept or on a SHIFT step.

## Timing
- Reset (`rst`=1 at an edge) forces: state IDLE, `data_out`=0, `cnt`=0, `busy`=0, `done`=0.
  - Reset overrides `start` and aborts any operation in flight, including mid-SHIFT.
- Latency: start accepted at edge k → `done`=1 during cycle k+amount+1 (after edge k+amount). Amount 0 gives `done` one cycle after accept.
- `busy`=1 for exactly `amount` cycles after accept; `busy` and `done` are never both high.
- Back-to-back: `start` during the DONE cycle is accepted. `done` falls and a new operation begins with no idle gap, so throughput is amount+1 cycles per operation.
- Outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Test plan
- Exhaustive 4-bit rotate right (WIDTH=4, mode=00, dir=0, amount=1), all 16 `data_in` values 0000..1111 → each `done` shows {d[0],d[3:1]}, e.g. 0001→1000, 0110→0011, and `done` arrives 2 cycles after `start`.
- WIDTH=8, mode=00, dir=1, `data_in`=8'b1000_0001, amount=3 → `busy` high 3 cycles, `data_out` steps 0000_0011, 0000_0110, 0000_1100, then `done`.
- WIDTH=8 boundaries:
  - Logical right, 8'hF0, amount=8 → 8'h00.
  - Arithmetic right, 8'h90, amount=3 → 8'hF2.
  - Rotate, 8'hA5, amount=8 → 8'hA5.
  - Amount=0 → 8'hA5 with `done` one cycle after `start` and `busy` never high.
- `start` pulsed mid-SHIFT with different data → ignored; the original result completes. A `start` held through the DONE cycle → the second operation starts immediately and `done` pulses twice with the correct results.
- `rst` asserted on the 2nd SHIFT cycle of an amount=5 operation → at the next edge `data_out`=0, `busy`=0, and no `done`. A subsequent `start` works normally.
- Reserved mode 11 with dir=0, 4'b0011, amount=1 → 4'b1001, identical to rotate.
